instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 40 ++++
 rtl/instr_fetch_unit_pc_update.sv | 30 +++
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch unit and control unit: control-word field
// positions, PC-select encodings and fetch FSM states.
package instr_fetch_unit_pkg;

  localparam int CW_W     = 34;
  localparam int CW_NS_HI = 33;
  localparam int CW_NS_LO = 32;
  localparam int CW_AS    = 31;
  localparam int CW_DS_HI = 30;
  localparam int CW_DS_LO = 29;
  localparam int CW_PS_HI = 28;
  localparam int CW_PS_LO = 27;
  localparam int CW_PCSEL = 26;
  localparam int CW_KSEL  = 25;
  localparam int CW_IL    = 24;
  localparam int CW_SL    = 23;
  localparam int CW_FS_HI = 22;
  localparam int CW_FS_LO = 18;
  localparam int CW_C0    = 17;
  localparam int CW_MW    = 16;
  localparam int CW_RW    = 15;
  localparam int CW_DA_HI = 14;
  localparam int CW_DA_LO = 10;
  localparam int CW_SA_HI = 9;
  localparam int CW_SA_LO = 5;
  localparam int CW_SB_HI = 4;
  localparam int CW_SB_LO = 0;

  typedef logic [1:0] ps_t;
  localparam ps_t PS_HOLD = 2'b00;
  localparam ps_t PS_INC4 = 2'b01;
  localparam ps_t PS_REL  = 2'b10;
  localparam ps_t PS_REG  = 2'b11;

  typedef logic [1:0] ifu_state_t;
  localparam ifu_state_t ST_IDLE  = 2'd0;
  localparam ifu_state_t ST_FETCH = 2'd1;
  localparam ifu_state_t ST_ERR   = 2'd2;

endpackage

// File: rtl/instr_fetch_unit_pc_update.sv
// Next-PC selection: hold, +4, word-scaled relative branch, or register jump.
// All arithmetic wraps modulo 2^64.
module instr_fetch_unit_pc_update
  import instr_fetch_unit_pkg::*;
(
  input  logic [63:0] pc,
  input  ps_t         ps,
  input  logic [63:0] k,
  input  logic [63:0] data_bus,
  output logic [63:0] pc_next,
  output logic [63:0] pc_plus4
);

  // k arrives sign-extended; its top two bits fall off the word scaling
  logic unused_k;
  assign unused_k = ^k[63:62];

  assign pc_plus4 = pc + 64'd4;

  always_comb begin
    pc_next = pc;
    case (ps)
      PS_INC4: pc_next = pc_plus4;
      PS_REL:  pc_next = pc + {k[61:0], 2'b00};
      PS_REG:  pc_next = data_bus;
      default: pc_next = pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, single-outstanding IR fetch with a wait
// budget, and the VCNZ status register. IFU_MISALIGN_TRAP_EN traps misaligned fetches.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC      = 64'h0,
  parameter int          FETCH_TIMEOUT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [33:0] cw,
  input  logic [63:0] k,
  input  logic [63:0] data_bus,
  input  logic [3:0]  alu_flags,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instruction,
  output logic [3:0]  status,
  output logic [63:0] pc,
  output logic [63:0] pc_plus4,
  output logic        stall,
  output logic        fetch_err
);

  localparam int            TW       = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(FETCH_TIMEOUT - 1);

  ifu_state_t    state_q, state_d;
  logic [63:0]   pc_q, pc_d, addr_q, addr_d, pc_next;
  logic [31:0]   ir_q, ir_d;
  logic [3:0]    status_q, status_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          il, sl, misalign;
  ps_t           ps;

  assign ps = cw[CW_PS_HI:CW_PS_LO];
  assign il = cw[CW_IL];
  assign sl = cw[CW_SL];

  // fields consumed by the datapath, not by fetch
  logic unused_cw;
  assign unused_cw = ^{cw[CW_NS_HI:CW_AS], cw[CW_DS_HI:CW_DS_LO],
                       cw[CW_PCSEL:CW_KSEL], cw[CW_FS_HI:CW_SB_LO]};

`ifdef IFU_MISALIGN_TRAP_EN
  assign misalign = |pc_q[1:0];
`else
  assign misalign = 1'b0;
`endif

  instr_fetch_unit_pc_update u_pc_update (
    .pc       (pc_q),
    .ps       (ps),
    .k        (k),
    .data_bus (data_bus),
    .pc_next  (pc_next),
    .pc_plus4 (pc_plus4)
  );

  assign stall     = (state_q != ST_IDLE);
  assign imem_req  = (state_q == ST_FETCH);
  assign fetch_err = (state_q == ST_ERR);
  assign imem_addr = addr_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tmo_d   = tmo_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: begin
        if (il) begin
          if (misalign) begin
            state_d = ST_ERR;
          end else begin
            // fetch address is the pre-update PC, word aligned
            state_d = ST_FETCH;
            addr_d  = {pc_q[63:2], 2'b00};
            tmo_d   = '0;
          end
        end
      end
      ST_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = ST_ERR;
    endcase
    pc_d     = stall ? pc_q : pc_next;
    status_d = sl ? alu_flags : status_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= '0;
      ir_q     <= '0;
      status_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      ir_q     <= ir_d;
      status_q <= status_d;
      tmo_q    <= tmo_d;
    end
  end

  assign pc          = pc_q;
  assign instruction = ir_q;
  assign status      = status_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed literal checks plus
// randomized traffic compared every cycle against a behavioural model.
module tb_instr_fetch_unit;

  localparam int          TMO = 8;
  localparam logic [63:0] RPC = 64'h0;
`ifdef IFU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [33:0] cw = '0;
  logic [63:0] k = '0, data_bus = '0;
  logic [3:0]  alu_flags = '0;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic        imem_req, stall, fetch_err;
  logic [63:0] imem_addr, pc, pc_plus4;
  logic [31:0] instruction;
  logic [3:0]  status;

  instr_fetch_unit #(.RESET_PC(RPC), .FETCH_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .cw(cw), .k(k), .data_bus(data_bus),
    .alu_flags(alu_flags), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .instruction(instruction),
    .status(status), .pc(pc), .pc_plus4(pc_plus4), .stall(stall), .fetch_err(fetch_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 waiting on memory, 2 faulted
  logic [63:0] m_pc, m_addr;
  logic [31:0] m_ir;
  logic [3:0]  m_st;
  int          m_mode, m_wait;

  function automatic logic [63:0] model_pc(input logic [63:0] p, input logic [1:0] s,
                                           input logic [63:0] kk, input logic [63:0] db);
    case (s)
      2'b01:   return p + 64'd4;
      2'b10:   return p + kk * 64'd4;
      2'b11:   return db;
      default: return p;
    endcase
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pc <= RPC; m_ir <= '0; m_st <= '0; m_mode <= 0; m_wait <= 0; m_addr <= '0;
    end else begin
      if (cw[23]) m_st <= alu_flags;
      if (m_mode == 0) begin
        m_pc <= model_pc(m_pc, cw[28:27], k, data_bus);
        if (cw[24]) begin
          if (TRAP && m_pc[1:0] != 2'b00) m_mode <= 2;
          else begin
            m_mode <= 1; m_wait <= 0; m_addr <= m_pc & ~64'h3;
          end
        end
      end else if (m_mode == 1) begin
        if (imem_valid) begin
          m_ir <= imem_rdata; m_mode <= 0;
        end else if (m_wait + 1 >= TMO) m_mode <= 2;
        else m_wait <= m_wait + 1;
      end
    end
  end

  always @(negedge clock) begin
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 64'd4);
    chk("instruction", {32'b0, instruction}, {32'b0, m_ir});
    chk("status", {60'b0, status}, {60'b0, m_st});
    chk("stall", {63'b0, stall}, {63'b0, m_mode != 0});
    chk("imem_req", {63'b0, imem_req}, {63'b0, m_mode == 1});
    chk("fetch_err", {63'b0, fetch_err}, {63'b0, m_mode == 2});
    if (m_mode == 1) chk("imem_addr", imem_addr, m_addr);
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  int starve = 0;

  initial begin
    // reset state, asynchronous
    #3;
    chk("rst_pc", pc, 64'h0);
    chk("rst_instr", {32'b0, instruction}, 64'h0);
    chk("rst_status", {60'b0, status}, 64'h0);
    chk("rst_stall", {63'b0, stall}, 64'h0);
    chk("rst_req", {63'b0, imem_req}, 64'h0);
    chk("rst_err", {63'b0, fetch_err}, 64'h0);
    @(negedge clock); #1;
    reset = 1'b1;

    // two-edge fetch latency, one stall cycle
    cw = '0; cw[24] = 1'b1; tick();
    chk("lat_stall_hi", {63'b0, stall}, 64'h1);
    chk("lat_req", {63'b0, imem_req}, 64'h1);
    chk("lat_addr", imem_addr, 64'h0);
    cw = '0; imem_valid = 1'b1; imem_rdata = 32'h8B020020; tick();
    chk("lat_ir", {32'b0, instruction}, 64'h8B020020);
    chk("lat_stall_lo", {63'b0, stall}, 64'h0);
    imem_valid = 1'b0;

    // relative branch and register jump
    cw = '0; cw[28:27] = 2'b11; data_bus = 64'h100; tick();
    chk("jmp_100", pc, 64'h100);
    cw[28:27] = 2'b10; k = 64'hFFFF_FFFF_FFFF_FFFE; tick();
    chk("rel_neg", pc, 64'hF8);
    cw[28:27] = 2'b11; data_bus = 64'h4000; tick();
    chk("jmp_4000", pc, 64'h4000);

    // fetch with simultaneous PC update, then PC frozen while stalled
    cw = '0; cw[24] = 1'b1; cw[28:27] = 2'b01; tick();
    chk("il_ps_addr", imem_addr, 64'h4000);
    chk("il_ps_pc", pc, 64'h4004);
    cw = '0; cw[28:27] = 2'b01; tick();
    chk("stall_hold", pc, 64'h4004);
    imem_valid = 1'b1; imem_rdata = 32'hD503201F; tick();
    chk("valid_hold", pc, 64'h4004);
    chk("valid_ir", {32'b0, instruction}, 64'hD503201F);
    imem_valid = 1'b0; tick();
    chk("after_inc", pc, 64'h4008);

    // status register
    cw = '0; cw[23] = 1'b1; alu_flags = 4'b0101; tick();
    chk("sl_set", {60'b0, status}, 64'h5);
    cw = '0; alu_flags = 4'b1010; tick();
    chk("sl_hold", {60'b0, status}, 64'h5);

    // wait budget exhaustion is sticky
    cw = '0; cw[24] = 1'b1; tick();
    cw = '0; repeat (TMO - 1) tick();
    chk("tmo_pre_err", {63'b0, fetch_err}, 64'h0);
    tick();
    chk("tmo_err", {63'b0, fetch_err}, 64'h1);
    chk("tmo_stall", {63'b0, stall}, 64'h1);
    chk("tmo_req", {63'b0, imem_req}, 64'h0);
    cw[28:27] = 2'b01; cw[24] = 1'b1; imem_valid = 1'b1; repeat (3) tick();
    chk("err_sticky", {63'b0, fetch_err}, 64'h1);
    chk("err_pc", pc, 64'h4008);
    chk("err_ir", {32'b0, instruction}, 64'hD503201F);
    imem_valid = 1'b0; cw = '0;
    reset = 1'b0; tick(); reset = 1'b1;
    chk("err_clr", {63'b0, fetch_err}, 64'h0);

    // reset mid-fetch drops the request, late valid ignored
    cw[24] = 1'b1; tick(); cw = '0;
    reset = 1'b0; #1;
    chk("midrst_req", {63'b0, imem_req}, 64'h0);
    imem_valid = 1'b1; imem_rdata = 32'hFFFF_FFFF; tick();
    reset = 1'b1; tick();
    chk("midrst_ir", {32'b0, instruction}, 64'h0);
    imem_valid = 1'b0;

    // misaligned PC fetch
    cw = '0; cw[28:27] = 2'b11; data_bus = 64'h102; tick();
    cw = '0; cw[24] = 1'b1; tick(); cw = '0;
`ifdef IFU_MISALIGN_TRAP_EN
    chk("mis_err", {63'b0, fetch_err}, 64'h1);
    chk("mis_req", {63'b0, imem_req}, 64'h0);
    tick();
    chk("mis_req2", {63'b0, imem_req}, 64'h0);
`else
    chk("mis_req", {63'b0, imem_req}, 64'h1);
    chk("mis_addr", imem_addr, 64'h100);
    imem_valid = 1'b1; tick(); imem_valid = 1'b0;
`endif
    reset = 1'b0; tick(); reset = 1'b1;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cw = 34'({$urandom, $urandom});
      cw[24] = ($urandom_range(0, 2) == 0);
      k = ($urandom_range(0, 1) == 0) ? 64'($signed($urandom_range(0, 64)) - 32)
                                      : {$urandom, $urandom};
      data_bus = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) data_bus[1:0] = 2'b00;
      alu_flags = 4'($urandom);
      imem_rdata = $urandom;
      if ($urandom_range(0, 63) == 0) starve = TMO + 2;
      imem_valid = (starve > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (starve > 0) starve--;
      if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 499) == 0)
        reset = 1'b0;
      else
        reset = 1'b1;
      tick();
    end
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
